// File: rtl/qpsk_tx_pkg.sv
// Shared constants and helpers for the QPSK TX mapper: FSM states, Gray decode,
// quadrant sign table, amplitude ceiling and sc16 packing.
package qpsk_tx_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  localparam logic [15:0] AMP_MAX = 16'h7FFF;

  // Gray decode of a dibit b1b0 into a quadrant index
  localparam logic [1:0] GRAY_00 = 2'd0;
  localparam logic [1:0] GRAY_01 = 2'd1;
  localparam logic [1:0] GRAY_11 = 2'd2;
  localparam logic [1:0] GRAY_10 = 2'd3;

  // Bit q set means that component is -A in quadrant q: 0(+,+) 1(-,+) 2(-,-) 3(+,-)
  localparam logic [3:0] QUAD_I_NEG = 4'b0110;
  localparam logic [3:0] QUAD_Q_NEG = 4'b1100;

  function automatic logic [1:0] gray_decode(input logic [1:0] dibit);
    logic [1:0] g;
    unique case (dibit)
      2'b00:   g = GRAY_00;
      2'b01:   g = GRAY_01;
      2'b11:   g = GRAY_11;
      default: g = GRAY_10;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] pack_sc16(input logic signed [15:0] i_val,
                                            input logic signed [15:0] q_val);
    return {i_val, q_val};
  endfunction

endpackage

// File: rtl/qpsk_quadrant_map.sv
// Combinational dibit-to-constellation mapper: Gray decode, optional differential
// phase accumulation, and signed I/Q selection from the quadrant sign table.
module qpsk_quadrant_map
  import qpsk_tx_pkg::*;
(
  input  logic [1:0]         dibit,
  input  logic [1:0]         phase,
  input  logic               diff_en,
  input  logic [15:0]        amp,
  output logic [1:0]         quad,
  output logic signed [15:0] i_val,
  output logic signed [15:0] q_val
);

  logic [1:0]         g;
  logic signed [15:0] pos_amp;
  logic signed [15:0] neg_amp;

  always_comb begin
    g       = gray_decode(dibit);
    // Two-bit add wraps naturally, giving (p + g) mod 4
    quad    = diff_en ? (phase + g) : g;
    pos_amp = signed'(amp);
    neg_amp = -pos_amp;
    i_val   = QUAD_I_NEG[quad] ? neg_amp : pos_amp;
    q_val   = QUAD_Q_NEG[quad] ? neg_amp : pos_amp;
  end

endmodule

// File: rtl/qpsk_symbol_mapper.sv
// QPSK TX front end: splits bytes into four dibits, maps each to an sc16 point
// and holds it for sps samples on a registered AXI-Stream output.
module qpsk_symbol_mapper
  import qpsk_tx_pkg::*;
#(
  parameter int SPS_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             axis_data_clk,
  input  logic             axis_data_rst,
  input  logic [SPS_W-1:0] cfg_sps,
  input  logic [15:0]      cfg_amp,
  input  logic             cfg_diff_en,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      stat_sym_count
);

  localparam logic [SPS_W-1:0] SPS_ONE = {{(SPS_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] clamp_amp(input logic [15:0] a);
    return (a > AMP_MAX) ? AMP_MAX : a;
  endfunction

  function automatic logic [SPS_W-1:0] eff_sps(input logic [SPS_W-1:0] s);
    return (s == '0) ? SPS_ONE : s;
  endfunction

  function automatic logic [1:0] pick_dibit(input logic [7:0] b, input logic [1:0] k);
    logic [2:0] base;
    base = MSB_FIRST ? {~k, 1'b0} : {k, 1'b0};
    return b[base +: 2];
  endfunction

  state_t             state;
  state_t             state_next;

  logic [7:0]         byte_r;
  logic               tlast_r;
  logic [SPS_W-1:0]   sps_r;
  logic [15:0]        amp_r;
  logic               diff_r;

  logic [SPS_W-1:0]   rep;
  logic [1:0]         idx;
  logic [1:0]         phase;

  logic               in_hs;
  logic               last_rep;
  logic               last_sym;
  logic               load;
  logic               adv_rep;
  logic               adv_sym;
  logic               finish;
  logic               sym_done;

  logic [1:0]         map_dibit;
  logic               map_diff;
  logic [15:0]        map_amp;
  logic [1:0]         map_quad;
  logic signed [15:0] map_i;
  logic signed [15:0] map_q;

  assign last_rep = (rep == sps_r - SPS_ONE);
  assign last_sym = last_rep && (idx == 2'd3);
  // Ready combines with downstream ready so the next byte loads with no bubble
  assign s_axis_tready = !axis_data_rst &&
                         ((state == ST_EMPTY) ||
                          ((state == ST_BUSY) && last_sym && m_axis_tready));
  assign in_hs    = s_axis_tvalid && s_axis_tready;
  assign sym_done = (state == ST_BUSY) && m_axis_tready && last_rep;

  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) state <= ST_EMPTY;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    adv_rep    = 1'b0;
    adv_sym    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_hs) begin
          load       = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_axis_tready) begin
          if (!last_rep)            adv_rep = 1'b1;
          else if (idx != 2'd3)     adv_sym = 1'b1;
          else if (in_hs)           load    = 1'b1;
          else begin
            finish     = 1'b1;
            state_next = ST_EMPTY;
          end
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // A fresh byte maps straight from the inputs; later dibits come from the held copy
  always_comb begin
    if (load) begin
      map_dibit = pick_dibit(s_axis_tdata, 2'd0);
      map_diff  = cfg_diff_en;
      map_amp   = clamp_amp(cfg_amp);
    end else begin
      map_dibit = pick_dibit(byte_r, idx + 2'd1);
      map_diff  = diff_r;
      map_amp   = amp_r;
    end
  end

  qpsk_quadrant_map u_map (
    .dibit   (map_dibit),
    .phase   (phase),
    .diff_en (map_diff),
    .amp     (map_amp),
    .quad    (map_quad),
    .i_val   (map_i),
    .q_val   (map_q)
  );

  always_ff @(posedge axis_data_clk) begin
    if (load) begin
      byte_r  <= s_axis_tdata;
      tlast_r <= s_axis_tlast;
      sps_r   <= eff_sps(cfg_sps);
      amp_r   <= clamp_amp(cfg_amp);
      diff_r  <= cfg_diff_en;
    end
  end

  // Output stage: registered sample, its tlast, and the symbol counters
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      rep            <= '0;
      idx            <= '0;
      phase          <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tlast   <= 1'b0;
      stat_sym_count <= '0;
    end else begin
      if (sym_done) stat_sym_count <= stat_sym_count + 32'd1;

      if (load || adv_sym) begin
        if (map_diff) phase <= map_quad;
        m_axis_tdata <= pack_sc16(map_i, map_q);
        rep          <= '0;
      end

      if (load) begin
        idx           <= 2'd0;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b0;
      end else if (adv_sym) begin
        idx          <= idx + 2'd1;
        m_axis_tlast <= tlast_r && (idx == 2'd2) && (sps_r == SPS_ONE);
      end else if (adv_rep) begin
        rep          <= rep + SPS_ONE;
        m_axis_tlast <= tlast_r && (idx == 2'd3) && ((rep + SPS_ONE) == (sps_r - SPS_ONE));
      end else if (finish) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Scoreboard bench for qpsk_symbol_mapper: a driver pushes model-predicted samples,
// a negedge monitor pops and compares every output handshake.
module tb_qpsk_symbol_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cfg_sps = 8'd1;
  logic [15:0] cfg_amp = 16'h2000;
  logic        cfg_diff_en = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] stat;

  qpsk_symbol_mapper #(.SPS_W(8), .MSB_FIRST(1'b1)) dut (
    .axis_data_clk  (clk),
    .axis_data_rst  (rst),
    .cfg_sps        (cfg_sps),
    .cfg_amp        (cfg_amp),
    .cfg_diff_en    (cfg_diff_en),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .stat_sym_count (stat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        sym_end;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] out_log[$];
  int total = 0;
  int bad = 0;
  int model_p = 0;
  int exp_syms = 0;
  int hs_count = 0;
  int tlast_seen = 0;
  int cyc = 0;
  int first_v = -1;
  int last_v = -1;
  int ready_at = -1;
  bit rand_ready = 1'b0;
  bit amp_jitter = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want completion", name);
  endtask

  // Reference: each byte is four MSB-first dibits, Gray-decoded, optionally
  // accumulated into the phase, each point repeated sps times.
  task automatic model_byte(input logic [7:0] b, input logic last);
    int gray_tab[4] = '{0, 1, 3, 2};
    int sps, a, d, g, q, iv, qv;
    logic [15:0] i16, q16;
    sps = (cfg_sps == 8'd0) ? 1 : int'(cfg_sps);
    a   = (cfg_amp > 16'h7FFF) ? 32'h7FFF : int'(cfg_amp);
    for (int k = 0; k < 4; k++) begin
      d = (int'(b) >> (6 - 2 * k)) & 3;
      g = gray_tab[d];
      if (cfg_diff_en) begin
        q = (model_p + g) % 4;
        model_p = q;
      end else begin
        q = g;
      end
      iv  = (q == 1 || q == 2) ? -a : a;
      qv  = (q >= 2) ? -a : a;
      i16 = iv[15:0];
      q16 = qv[15:0];
      for (int r = 0; r < sps; r++)
        exp_q.push_back('{data: {i16, q16}, last: (last && k == 3 && r == sps - 1),
                          sym_end: (r == sps - 1)});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    s_tdata  = b;
    s_tlast  = last;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        model_byte(b, last);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        if (amp_jitter) cfg_amp = 16'($urandom);
        return;
      end
      @(posedge clk); #1;
      if (amp_jitter) cfg_amp = 16'($urandom);
      n++;
      if (n > 500) begin
        timeout("send_byte");
        s_tvalid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) timeout("drain");
    chk("stat_sym_count", stat, 32'(exp_syms));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_p = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_s_tready", s_tready, 1'b0);
    chk_bit("rst_m_tvalid", m_tvalid, 1'b0);
    chk_bit("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_stat", stat, 32'h0);
    rst = 1'b0;
    #1;
    chk_bit("post_rst_s_tready", s_tready, 1'b1);
  endtask

  task automatic chk_log(input string name, input int i, input logic [31:0] req);
    logic [31:0] act;
    act = (i < out_log.size()) ? out_log[i] : 32'hxxxx_xxxx;
    chk(name, act, req);
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
      exp_q.delete();
      exp_syms = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_tdata", m_tdata, held_data);
        chk_bit("stall_tlast", m_tlast, held_last);
      end
      if (m_tvalid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (m_tvalid && m_tready) begin
        hs_count++;
        if (s_tready && ready_at < 0) ready_at = hs_count;
        if (m_tlast) tlast_seen++;
        out_log.push_back(m_tdata);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got %08h want none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("sample_tdata", m_tdata, e.data);
          chk_bit("sample_tlast", m_tlast, e.last);
          if (e.sym_end) exp_syms++;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      held_data  = m_tdata;
      held_last  = m_tlast;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tl0, hs0, n;
    do_reset();

    // Plain Gray map, one sample per symbol
    cfg_amp = 16'h2000; cfg_sps = 8'd1; cfg_diff_en = 1'b0;
    out_log.delete();
    tl0 = tlast_seen;
    send_byte(8'h1B, 1'b1);
    wait_drain();
    chk_log("t1_s0", 0, 32'h20002000);
    chk_log("t1_s1", 1, 32'hE0002000);
    chk_log("t1_s2", 2, 32'h2000E000);
    chk_log("t1_s3", 3, 32'hE000E000);
    chk("t1_tlast_count", 32'(tlast_seen - tl0), 32'd1);
    chk("t1_stat", stat, 32'd4);

    // Differential encoding from a cleared phase
    do_reset();
    cfg_diff_en = 1'b1;
    out_log.delete();
    send_byte(8'h55, 1'b0);
    wait_drain();
    chk_log("t2_s0", 0, 32'hE0002000);
    chk_log("t2_s1", 1, 32'hE000E000);
    chk_log("t2_s2", 2, 32'h2000E000);
    chk_log("t2_s3", 3, 32'h20002000);
    out_log.delete();
    send_byte(8'h00, 1'b0);
    wait_drain();
    for (int i = 0; i < 4; i++) chk_log("t2_zero", i, 32'h20002000);

    // Back-to-back bytes with sps=4
    cfg_diff_en = 1'b0; cfg_sps = 8'd4;
    hs_count = 0; first_v = -1; last_v = -1; ready_at = -1;
    send_byte(8'h1B, 1'b0);
    send_byte(8'hE4, 1'b1);
    wait_drain();
    chk("t3_samples", 32'(hs_count), 32'd32);
    chk("t3_no_bubble", 32'(last_v - first_v + 1), 32'd32);
    chk("t3_ready_at", 32'(ready_at), 32'd16);

    // Random backpressure, random bytes, amplitude jitter mid-byte
    cfg_sps = 8'd3;
    rand_ready = 1'b1;
    amp_jitter = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cfg_diff_en = 1'($urandom_range(0, 1));
      send_byte(8'($urandom), 1'($urandom_range(0, 1)));
    end
    amp_jitter = 1'b0;
    wait_drain();
    rand_ready = 1'b0;

    // Amplitude saturation and sps=0 treated as 1
    cfg_amp = 16'h8000; cfg_sps = 8'd0; cfg_diff_en = 1'b0;
    out_log.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b1);
    wait_drain();
    for (int i = 0; i < 4; i++) chk_log("t5_pos", i, 32'h7FFF7FFF);
    for (int i = 4; i < 8; i++) chk_log("t5_mix", i, 32'h7FFF8001);

    // Reset after two samples of a tlast byte
    cfg_amp = 16'h2000; cfg_sps = 8'd1; cfg_diff_en = 1'b1;
    tl0 = tlast_seen;
    hs0 = hs_count;
    send_byte(8'h55, 1'b1);
    n = 0;
    while (hs_count < hs0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("t6_two_samples");
    @(posedge clk); #1;
    rst = 1'b1;
    model_p = 0;
    @(posedge clk); #1;
    chk_bit("t6_tvalid", m_tvalid, 1'b0);
    chk_bit("t6_tlast", m_tlast, 1'b0);
    chk("t6_stat", stat, 32'd0);
    rst = 1'b0;
    out_log.delete();
    send_byte(8'h55, 1'b0);
    wait_drain();
    chk_log("t6_restart0", 0, 32'hE0002000);
    chk_log("t6_restart3", 3, 32'h20002000);
    chk("t6_no_tlast", 32'(tlast_seen - tl0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_mapper.md
Name: qpsk_symbol_mapper

Overview:
TX-side QPSK modulator front end for the RFNoC datapath. It takes a byte stream and splits each byte into four dibits. Each dibit is Gray-mapped, with optional differential encoding, to a signed sc16 constellation point. Each point is held for cfg_sps output samples, and the result is emitted as a {I[31:16],Q[15:0]} AXI-Stream toward the noc_shell payload port or an RRC interpolator. Differential encoding lets the far-end carrier-recovery loop resolve its 4-fold phase ambiguity.

Parameters:
SPS_W, 8, width of cfg_sps.
MSB_FIRST, 1, 1: dibit [7:6] is sent first; 0: dibit [1:0] is sent first.

Ports:
axis_data_clk  in  1  clock, single domain
axis_data_rst  in  1  synchronous, active-high reset
cfg_sps  in  SPS_W  samples per symbol; 0 is treated as 1
cfg_amp  in  16  constellation amplitude A, unsigned magnitude
cfg_diff_en  in  1  enables differential encoding
s_axis_tdata  in  8  input byte
s_axis_tlast  in  1  last byte of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  32  {I,Q}, two's complement
m_axis_tlast  out  1  last sample of packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
stat_sym_count  out  32  count of symbols fully emitted; wraps

Behaviour:
- Reset values: s_axis_tready=0 during reset and 1 on the first cycle after; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, stat_sym_count=0. Internal state is cleared: phase accumulator p=0, held byte discarded.
- States:
  - EMPTY: s_axis_tready=1, m_axis_tvalid=0.
  - BUSY: a byte is held; m_axis_tvalid=1.
- Transitions:
  - EMPTY→BUSY on an input handshake.
  - BUSY→EMPTY on the output handshake of the last sample of dibit 3, if no new byte arrives that cycle.
- s_axis_tready = EMPTY, or (BUSY and last sample of last dibit and m_axis_tready). This allows back-to-back bytes with no bubble.
- Latency: byte accepted in cycle N; its first sample appears on m_axis in cycle N+1. All outputs are registered.
- On byte accept, the block latches the byte, tlast, sps_eff=max(cfg_sps,1), A_eff=min(cfg_amp,0x7FFF) and diff_en. Config changes have no effect on a held byte.
- Counters:
  - rep counter runs 0..sps_eff-1 and advances on each output handshake.
  - At wrap, the dibit index advances 0..3.
  - On the last sample of a dibit, stat_sym_count increments by 1.
- Gray decode g(b1b0): 00→0, 01→1, 11→2, 10→3.
- Quadrant q:
  - diff off: q=g.
  - diff on: q=(p+g) mod 4, and p<=q. p updates once per symbol, at symbol load, not per sample.
  - p persists across packets and is cleared only by reset.
- Point for q: 0→(+A,+A), 1→(−A,+A), 2→(−A,−A), 3→(+A,−A). −A is the 16-bit two's complement of A_eff.
- m_axis_tlast=1 only on the final sample of dibit 3 of a byte latched with tlast=1.
- While m_axis_tvalid=1 and m_axis_tready=0, tdata and tlast hold stable (AXI rule). Nothing advances.
- Reset mid-byte: the remaining samples are dropped and no tlast is generated.

Decomposition:
- Package qpsk_tx_pkg holds:
  - the Gray-decode constants,
  - the quadrant sign table,
  - the AMP_MAX=16'h7FFF constant,
  - the sc16 packing helper.
- One sub-module, qpsk_quadrant_map, is natural: combinational {dibit, p, diff_en, A} → {q_next, I, Q}. All sequencing stays in the top.

Test Plan:
1. A=0x2000, sps=1, diff off, byte 0x1B with tlast → 0x20002000, 0xE0002000, 0x2000E000, 0xE000E000; tlast only on the 4th sample; stat_sym_count=4.
2. diff on, after reset, byte 0x55 → 0xE0002000, 0xE000E000, 0x2000E000, 0x20002000; then byte 0x00 → 0x20002000 ×4.
3. sps=4, bytes 0x1B then 0xE4 back-to-back, m_axis_tready held high → 32 samples with no bubble; each point repeated 4×; s_axis_tready pulses in the same cycle as sample 16.
4. sps=3, m_axis_tready toggled randomly, changing cfg_amp mid-byte → output matches a reference model; tdata stable while stalled; new A is applied from the next byte only.
5. cfg_amp=0x8000, cfg_sps=0, byte 0x00 → four samples of 0x7FFF7FFF; byte 0xAA → four samples of 0x7FFF8001.
6. Reset asserted after 2 samples of a tlast byte → m_axis_tvalid=0 the next cycle; p=0; no tlast seen; the next byte restarts cleanly.
